// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480 VGA timing constants and receiver FSM encoding
package vga_timing_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_H_TOTAL   = 800;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;
  localparam int VGA_V_TOTAL   = 525;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/vga_rx_checksum.sv
// rtl/vga_rx_checksum.sv - rotate/xor frame signature over the visible pixels
module vga_rx_checksum
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int V_VISIBLE = VGA_V_VISIBLE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixel_valid,
  input  logic        frame_start,
  input  logic [11:0] pix_rgb,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic [15:0] frame_sig,
  output logic        sig_valid
);

  localparam logic [9:0] X_LAST = 10'(H_VISIBLE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_VISIBLE - 1);

  logic [15:0] sig;
  logic [15:0] sig_nxt;

  // Clearing at frame_start folds the first pixel into a zero signature.
  always_comb begin
    sig_nxt = {sig[14:0], sig[15]} ^ {4'h0, pix_rgb};
    if (frame_start) begin
      sig_nxt = {4'h0, pix_rgb};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig       <= '0;
      frame_sig <= '0;
      sig_valid <= 1'b0;
    end else begin
      sig_valid <= 1'b0;
      if (pixel_valid) begin
        sig <= sig_nxt;
        if (x == X_LAST && y == Y_LAST) begin
          frame_sig <= sig_nxt;
          sig_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - VGA sync lock, pixel coordinate recovery and timing fault flags
// Frame signature logic is built only when VGA_RX_FRAME_SIG_EN is defined.
module vga_sync_receiver
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_TOTAL   = VGA_H_TOTAL,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_TOTAL   = VGA_V_TOTAL,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic [11:0] pix_rgb,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        pixel_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [7:0]  frame_count,
  output logic [15:0] frame_sig,
  output logic        sig_valid
);

  localparam logic [10:0] H_SAT   = 11'(2 * H_TOTAL - 1);
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_START = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END   = 11'(H_SYNC + H_BP + H_VISIBLE);
  localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BP + V_VISIBLE);
  localparam logic [9:0]  V_FULL  = 10'(V_TOTAL);
  localparam logic [9:0]  V_SAT   = 10'h3FF;

  logic        hs_r, vs_r, hs_rr, vs_rr;
  logic [11:0] rgb_r;
  logic        hs_fall, vs_fall;
  logic [10:0] h_cnt, h_pos;
  logic [9:0]  v_line, v_pos;
  logic        h_seen;
  logic        line_fault, frame_fault;
  rx_state_t   state, state_nxt;
  logic        locked_d, h_err_d, v_err_d;
  logic        pv_d, fs_d;
  logic [9:0]  x_d, y_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_r  <= 1'b0;
      vs_r  <= 1'b0;
      hs_rr <= 1'b0;
      vs_rr <= 1'b0;
      rgb_r <= '0;
    end else begin
      hs_r  <= hsync;
      vs_r  <= vsync;
      hs_rr <= hs_r;
      vs_rr <= vs_r;
      rgb_r <= {red, green, blue};
    end
  end

  assign hs_fall = hs_rr & ~hs_r;
  assign vs_fall = vs_rr & ~vs_r;

  // h_pos/v_pos are the counts belonging to the pixel currently in stage 1.
  always_comb begin
    if (hs_fall)               h_pos = '0;
    else if (h_cnt == H_SAT)   h_pos = H_SAT;
    else                       h_pos = h_cnt + 11'd1;

    if (vs_fall)                         v_pos = '0;
    else if (hs_fall && v_line != V_SAT) v_pos = v_line + 10'd1;
    else                                 v_pos = v_line;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt  <= '0;
      v_line <= '0;
      h_seen <= 1'b0;
    end else begin
      h_cnt  <= h_pos;
      v_line <= v_pos;
      if (hs_fall) begin
        h_seen <= 1'b1;
      end
    end
  end

  assign line_fault  = (hs_fall && h_seen && h_cnt != H_LAST) ||
                       (h_pos == H_SAT && h_cnt != H_SAT);
  assign frame_fault = vs_fall && (v_line != V_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_SEARCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_SEARCH: begin
        if (vs_fall) state_nxt = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (line_fault)                         state_nxt = ST_SEARCH;
        else if (vs_fall && v_line == V_FULL)   state_nxt = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (line_fault || frame_fault) state_nxt = ST_SEARCH;
      end
      default: state_nxt = ST_SEARCH;
    endcase
  end

  always_comb begin
    locked_d = (state == ST_LOCKED);
    h_err_d  = locked_d && line_fault;
    v_err_d  = locked_d && frame_fault;
  end

  always_comb begin
    pv_d = locked_d && (h_pos >= H_START) && (h_pos < H_END) &&
           (v_pos >= V_START) && (v_pos < V_END);
    x_d  = '0;
    y_d  = '0;
    if (pv_d) begin
      x_d = 10'(h_pos - H_START);
      y_d = v_pos - V_START;
    end
    fs_d = pv_d && (x_d == '0) && (y_d == '0);
  end

  // Stage 2: every output is registered here, two clocks after the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_rgb     <= '0;
      x           <= '0;
      y           <= '0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      frame_count <= '0;
    end else begin
      pix_rgb     <= rgb_r;
      x           <= x_d;
      y           <= y_d;
      pixel_valid <= pv_d;
      frame_start <= fs_d;
      locked      <= locked_d;
      h_err       <= h_err_d;
      v_err       <= v_err_d;
      if (fs_d) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

`ifdef VGA_RX_FRAME_SIG_EN
  vga_rx_checksum #(
    .H_VISIBLE(H_VISIBLE),
    .V_VISIBLE(V_VISIBLE)
  ) u_checksum (
    .clk        (clk),
    .rst        (rst),
    .pixel_valid(pixel_valid),
    .frame_start(frame_start),
    .pix_rgb    (pix_rgb),
    .x          (x),
    .y          (y),
    .frame_sig  (frame_sig),
    .sig_valid  (sig_valid)
  );
`else
  assign frame_sig = '0;
  assign sig_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb/tb_vga_sync_receiver.sv - directed bench for vga_sync_receiver on a reduced raster
module tb_vga_sync_receiver;

  localparam int HV = 16, HFP = 2, HS = 4, HBP = 3, HT = 25;
  localparam int VV = 10, VFP = 2, VS = 2, VBP = 3, VT = 17;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsync, vsync;
  logic [3:0]  red, green, blue;
  logic [11:0] pix_rgb;
  logic [9:0]  x, y;
  logic        pixel_valid, frame_start, locked, h_err, v_err, sig_valid;
  logic [7:0]  frame_count;
  logic [15:0] frame_sig;

  int vectors = 0;
  int miscompares = 0;

  int  nh, nv, cur_hc, cur_vc, line_len, frame_len;
  bit  src_en = 0, hs_hold = 0, white_on = 0, stretch_arm = 0, short_arm = 0, pix_on;
  int  white_hc = 0, white_vc = 0, stretch_vc = 0;

  int h_err_cnt = 0, v_err_cnt = 0, pv_cnt = 0, frame_pv = 0, sv_cnt = 0;

  vga_sync_receiver #(
    .H_VISIBLE(HV), .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .pix_rgb(pix_rgb), .x(x), .y(y), .pixel_valid(pixel_valid),
    .frame_start(frame_start), .locked(locked), .h_err(h_err), .v_err(v_err),
    .frame_count(frame_count), .frame_sig(frame_sig), .sig_valid(sig_valid)
  );

  always #5 clk = ~clk;

  // Raster source: visible area first, then front porch, sync, back porch.
  initial begin
    hsync = 1'b1; vsync = 1'b1; red = 4'h0; green = 4'h0; blue = 4'h0;
    nh = 0; nv = 0; cur_hc = -1; cur_vc = -1;
    forever begin
      @(posedge clk); #1;
      if (src_en) begin
        cur_hc = nh; cur_vc = nv;
        hsync  = hs_hold || !(nh >= HV + HFP && nh < HV + HFP + HS);
        vsync  = !(nv >= VV + VFP && nv < VV + VFP + VS);
        pix_on = white_on && nh == white_hc && nv == white_vc;
        red    = pix_on ? 4'hF : 4'h0;
        green  = pix_on ? 4'hF : 4'h0;
        blue   = pix_on ? 4'hF : 4'h0;
        line_len = (stretch_arm && nv == stretch_vc) ? HT + 1 : HT;
        if (nh >= line_len - 1) begin
          nh = 0;
          if (stretch_arm && nv == stretch_vc) stretch_arm = 0;
          frame_len = short_arm ? VT - 1 : VT;
          if (nv >= frame_len - 1) begin
            nv = 0;
            short_arm = 0;
          end else begin
            nv++;
          end
        end else begin
          nh++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (h_err) h_err_cnt++;
    if (v_err) v_err_cnt++;
    if (sig_valid) sv_cnt++;
    if (frame_start) begin
      frame_pv = pv_cnt;
      pv_cnt = 1;
    end else if (pixel_valid) begin
      pv_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pins(input string tag, input int hc, input int vc);
    bit found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      if (cur_hc == hc && cur_vc == vc) found = 1;
    end
    check({"reach_", tag}, 32'(found), 32'd1);
  endtask

  task automatic wait_locked(input string tag);
    bit found = 0;
    for (int k = 0; k < 3000 && !found; k++) begin
      @(negedge clk);
      if (locked) found = 1;
    end
    check({"relock_", tag}, 32'(found), 32'd1);
  endtask

`ifdef VGA_RX_FRAME_SIG_EN
  task automatic wait_sig(input string tag, input logic [15:0] exp);
    bit found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      if (sig_valid) found = 1;
    end
    check({"sigv_", tag}, 32'(found), 32'd1);
    check({"sig_", tag}, 32'(frame_sig), 32'(exp));
  endtask
`endif

  int sv0;

  initial begin
    rst = 1'b1;
    tick(3);
    check("rst_valid", {pixel_valid, frame_start, locked, h_err, v_err, sig_valid}, 0);
    check("rst_xy", {x, y}, 0);
    check("rst_rgb_cnt", {pix_rgb, frame_count}, 0);
    check("rst_sig", 32'(frame_sig), 0);
    rst = 1'b0;
    tick(1);
    src_en = 1;

    // lock acquisition
    wait_pins("vs1", 0, VV + VFP);
    tick(3);
    check("lock_after_vs1", 32'(locked), 0);
    wait_pins("vs2", 0, VV + VFP);
    tick(2);
    check("lock_vs2_n2", 32'(locked), 0);
    tick(1);
    check("lock_vs2_n3", 32'(locked), 1);
    wait_pins("f0", 0, 0);
    tick(1);
    check("fs_early", {frame_start, frame_count}, 0);
    tick(1);
    check("fs_pulse", {frame_start, pixel_valid}, 2'b11);
    check("fs_xy", {x, y}, 0);
    check("fs_count", 32'(frame_count), 1);

    // single white pixel and visible-area boundaries
    white_hc = 5; white_vc = 7; white_on = 1;
    wait_pins("w57", 5, 7);
    tick(2);
    check("w_rgb", 32'(pix_rgb), 32'hFFF);
    check("w_xy", {x, y}, {10'd5, 10'd7});
    check("w_pv", 32'(pixel_valid), 1);
    tick(1);
    check("w_next", {pix_rgb, x}, {12'h000, 10'd6});
    white_on = 0;
    wait_pins("last", HV - 1, VV - 1);
    tick(2);
    check("last_xy", {pixel_valid, x, y}, {1'b1, 10'd15, 10'd9});
    tick(1);
    check("fp_blank", {pixel_valid, x, y}, 0);
    wait_pins("f1", 0, 0);
    tick(3);
    check("pv_per_frame", frame_pv, HV * VV);
    check("fcount2", 32'(frame_count), 2);

    // 26-clock line while locked
    wait_pins("f2", 0, 0);
    stretch_vc = 3; stretch_arm = 1;
    wait_pins("hfall", HV + HFP, 4);
    tick(1);
    check("herr_pre", 32'(h_err), 0);
    tick(1);
    check("herr_pulse", {h_err, locked}, 2'b11);
    tick(1);
    check("herr_drop", {h_err, locked}, 2'b00);
    wait_pins("rl_vs1", 0, VV + VFP);
    tick(3);
    check("rl_vs1_lock", 32'(locked), 0);
    wait_pins("rl_vs2", 0, VV + VFP);
    tick(2);
    check("rl_vs2_n2", 32'(locked), 0);
    tick(1);
    check("rl_vs2_n3", 32'(locked), 1);
    check("herr_count", h_err_cnt, 1);

    // 16-line frame while locked, then silent timeout
    wait_pins("f_short", 0, 0);
    short_arm = 1;
    wait_pins("vs_ok", 0, VV + VFP);
    tick(2);
    check("verr_none", 32'(v_err), 0);
    wait_pins("vs_bad", 0, VV + VFP);
    tick(2);
    check("verr_pulse", {v_err, locked}, 2'b11);
    tick(1);
    check("verr_drop", {v_err, locked}, 2'b00);
    hs_hold = 1;
    tick(600);
    check("silent_timeout", {h_err_cnt[15:0], v_err_cnt[15:0]}, {16'd1, 16'd1});
    check("hold_unlocked", 32'(locked), 0);
    hs_hold = 0;

    // reset mid-frame
    wait_locked("pre_rst");
    wait_pins("y5", 3, 5);
    tick(2);
    check("pre_rst_xy", {x, y}, {10'd3, 10'd5});
    rst = 1'b1;
    #1;
    check("rst_mid_flags", {pixel_valid, frame_start, locked, h_err, v_err}, 0);
    check("rst_mid_data", {x, y, pix_rgb}, 0);
    check("rst_mid_cnt", 32'(frame_count), 0);
    tick(2);
    rst = 1'b0;
    wait_pins("r_vs1", 0, VV + VFP);
    tick(3);
    check("r_vs1_lock", 32'(locked), 0);
    wait_pins("r_vs2", 0, VV + VFP);
    tick(2);
    check("r_vs2_n2", 32'(locked), 0);
    tick(1);
    check("r_vs2_n3", 32'(locked), 1);
    wait_pins("r_f0", 0, 0);
    tick(2);
    check("r_fs", {frame_start, frame_count}, {1'b1, 8'd1});

`ifdef VGA_RX_FRAME_SIG_EN
    white_hc = 0; white_vc = 0; white_on = 1;
    wait_sig("black0", 16'h0000);
    sv0 = sv_cnt;
    wait_sig("white00", 16'h87FF);
    white_on = 0;
    check("sigv_once", sv_cnt - sv0, 1);
    wait_sig("black1", 16'h0000);
`else
    sv0 = sv_cnt;
    wait_pins("s_f1", 0, 0);
    wait_pins("s_f2", 0, 0);
    check("no_sig", {16'(sv_cnt - sv0), frame_sig}, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
